cpu_mem_arbiter: RTL
====================

Name: cpu_mem_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester (inst) and the load/store requester (data) of the MIPS pipeline.
- Handshake is split-transaction: req/addr_ok for the address phase, data_ok/rdata for the data phase.
- Tracks in-order outstanding transactions in an owner FIFO and steers each data_ok back to the requester that issued it.
- Sits between the pipeline stages and the cache/AXI bridge.

Parameters:
- OUTSTANDING, 2: maximum accepted-but-unreturned transactions (owner FIFO depth, ≥1).
- STARVE_LIMIT, 8: consecutive cycles inst may wait while data wins before inst gets priority (≥1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req / data_req  in  1  request valid; requester holds all request fields stable until its addr_ok
- inst_wr / data_wr  in  1  1 = write
- inst_size / data_size  in  2  0 = byte, 1 = half, 2 = word
- inst_addr / data_addr  in  32  byte address
- inst_wdata / data_wdata  in  32  write data
- inst_addr_ok / data_addr_ok  out  1  address phase accepted this cycle
- inst_data_ok / data_data_ok  out  1  data phase complete this cycle
- inst_rdata / data_rdata  out  32  read data, valid with the matching data_ok
- mem_req  out  1  request to memory
- mem_wr, mem_size, mem_addr, mem_wdata  out  1/2/32/32  muxed request fields
- mem_addr_ok  in  1  memory accepted the address phase
- mem_data_ok  in  1  memory returning a data phase, in order
- mem_rdata  in  32  read data
- err  out  1  sticky: mem_data_ok arrived with the owner FIFO empty

Behaviour:
- Reset: owner FIFO emptied, lock cleared, starve counter = 0, err = 0.
  - While reset is high: mem_req = 0, both addr_ok = 0, both data_ok = 0.
- Grant is combinational when no lock is held:
  - No request is granted while the FIFO is full.
  - Otherwise data wins over inst, except when starve_cnt ≥ STARVE_LIMIT; then inst wins.
  - With one requester, that requester is granted.
- mem_req = granted requester's req.
- mem_wr, mem_size, mem_addr, mem_wdata are muxed from the granted requester; they are 0 when there is no grant.
- Address accept: x_addr_ok = mem_addr_ok & mem_req & (grant == x), combinational.
- Lock:
  - If mem_req = 1 and mem_addr_ok = 0, register lock_valid = 1 and lock_owner = grant.
  - While locked, grant = lock_owner regardless of the other request, FIFO full state, or starve count.
  - The lock clears in the cycle mem_addr_ok is seen.
  - Memory must never see the address change mid-request.
- Lock entry can only happen when the FIFO is not full, so an accept under lock always has a free FIFO slot.
- Owner FIFO:
  - Width 1: 0 = inst, 1 = data. Depth OUTSTANDING, pointers wrap modulo depth.
  - Push the owner on mem_req & mem_addr_ok.
  - Pop on mem_data_ok when not empty.
- Simultaneous push and pop:
  - Both take effect; count is unchanged.
  - When full, a new grant is still blocked that cycle (full is evaluated on the registered count), except the lock case above.
- Data return:
  - x_data_ok = mem_data_ok & !empty & (head == x).
  - x_rdata = mem_rdata, unregistered; the non-owner's data_ok stays 0.
  - Latency from mem_data_ok to x_data_ok is 0 cycles.
  - Writes also produce data_ok (write ack).
- mem_data_ok with the FIFO empty: ignored (no data_ok to either requester), err <= 1 until reset.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) in each cycle inst_req = 1, data is granted, and no inst accept occurs.
  - Clears on an inst_addr_ok or when inst_req = 0.
- Reset mid-transaction drops all outstanding owners. A later mem_data_ok for a pre-reset transaction sets err; the memory side is expected to be reset together with this block.
- Same-cycle accept and return for the same requester is legal: e.g. inst gets data_ok for an older fetch and addr_ok for a new one in one cycle.

Decomposition:
- Shared constant in the mycpu.h-style header: OWNER_INST = 1'b0 and OWNER_DATA = 1'b1 (owner ID encoding).
- SRAM-like size encodings go in the same header.
- One sub-module: mem_owner_fifo, a parameterised 1-bit-wide synchronous FIFO.
  - Ports: push, pop, din, dout, empty, full.
  - Read is combinational from the head.
- Arbitration, lock, and starve logic stay in cpu_mem_arbiter.

Test Plan:
- Single fetch:
  - Stimulus: inst_req with addr 0xbfc00000 and size 2; mem_addr_ok in the same cycle; mem_data_ok 2 cycles later with rdata 0x24010001.
  - Required: inst_addr_ok in cycle 0; inst_data_ok = 1 and inst_rdata = 0x24010001 in cycle 2; data_data_ok = 0 throughout.
- Contention:
  - Stimulus: inst_req and data_req both raised in cycle 0 (data addr 0x80000010, inst addr 0xbfc00004); mem_addr_ok held 1.
  - Required: mem_addr = 0x80000010 in cycle 0 and 0xbfc00004 in cycle 1; returns in that order, steered to data then inst.
- Lock:
  - Stimulus: data_req granted with mem_addr_ok = 0 for 3 cycles; inst_req raised in cycle 1.
  - Required: mem_addr stays at the data address all 4 cycles; data_addr_ok in cycle 3; inst granted in cycle 4.
- Full:
  - Stimulus: OUTSTANDING = 2; two reads accepted; no mem_data_ok; third request pending.
  - Required: mem_req = 0 until one mem_data_ok; third grant and accept occur in the next cycle.
- Starvation:
  - Stimulus: data_req held continuously; inst_req high; mem_addr_ok = 1.
  - Required: inst_addr_ok exactly on the 9th cycle (after 8 data grants); starve count returns to 0.
- Reset / stray return:
  - Stimulus: reset asserted with 2 outstanding; release; then pulse mem_data_ok.
  - Required: no data_ok to either requester; err = 1 and remains set until the next reset.

Source files
------------

// File: rtl/cpu_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mem_arbiter_pkg
//  Description : Shared encodings for the CPU memory-port arbiter: owner IDs
//                carried in the owner FIFO and SRAM-like transfer sizes.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_mem_arbiter_pkg;

    // Owner ID stored per outstanding transaction
    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    // SRAM-like size encodings
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage : cpu_mem_arbiter_pkg
`default_nettype wire

// File: rtl/cpu_mem_arbiter_owner_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mem_owner_fifo
//  Description : 1-bit-wide synchronous FIFO recording which requester owns
//                each accepted-but-unreturned memory transaction. The head is
//                read combinationally so a return can be steered in the same
//                cycle it arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_owner_fifo
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic empty,
    output logic full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem_q,    mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign dout  = mem_q[rd_ptr_q];

    // Next-state: a push into a full FIFO is only honoured when a pop frees a slot
    always_comb begin
        do_push  = push & (~full | pop);
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : mem_owner_fifo
`default_nettype wire

// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mem_arbiter
//  Description : Shares one SRAM-like split-transaction memory port between
//                the instruction-fetch and load/store requesters. Data has
//                priority unless inst has been starved; an un-accepted request
//                locks the grant so the address never changes mid-request.
//                Returns are steered in order via an owner FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int OUTSTANDING  = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    // instruction-fetch requester
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // load/store requester
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // memory side
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    // status
    output logic        err
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic                lock_valid_q, lock_valid_d;
    logic                lock_owner_q, lock_owner_d;
    logic [STARVE_W-1:0] starve_q,     starve_d;
    logic                err_q,        err_d;

    logic grant_valid;
    logic grant_owner;
    logic fifo_push;
    logic fifo_pop;
    logic fifo_head;
    logic fifo_empty;
    logic fifo_full;

    // Grant selection: a held lock overrides everything; otherwise data wins
    // unless inst has waited STARVE_LIMIT cycles. Nothing new while full.
    always_comb begin
        grant_valid = 1'b0;
        grant_owner = OWNER_DATA;
        if (lock_valid_q) begin
            grant_valid = 1'b1;
            grant_owner = lock_owner_q;
        end else if (!fifo_full) begin
            if (data_req && !(inst_req && (starve_q >= STARVE_W'(STARVE_LIMIT)))) begin
                grant_valid = 1'b1;
                grant_owner = OWNER_DATA;
            end else if (inst_req) begin
                grant_valid = 1'b1;
                grant_owner = OWNER_INST;
            end
        end
    end

    // Request mux toward memory; fields read as zero when nothing is granted
    always_comb begin
        mem_req   = ~reset & grant_valid &
                    ((grant_owner == OWNER_INST) ? inst_req : data_req);
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (mem_req) begin
            if (grant_owner == OWNER_INST) begin
                mem_wr    = inst_wr;
                mem_size  = inst_size;
                mem_addr  = inst_addr;
                mem_wdata = inst_wdata;
            end else begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end
        end
    end

    // Address accept, owner tracking and return steering
    always_comb begin
        fifo_push    = mem_req & mem_addr_ok;
        fifo_pop     = ~reset & mem_data_ok & ~fifo_empty;
        inst_addr_ok = fifo_push & (grant_owner == OWNER_INST);
        data_addr_ok = fifo_push & (grant_owner == OWNER_DATA);
        inst_data_ok = fifo_pop  & (fifo_head == OWNER_INST);
        data_data_ok = fifo_pop  & (fifo_head == OWNER_DATA);
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
        err          = err_q;
    end

    // Next-state for lock, starvation counter and sticky error
    always_comb begin
        lock_valid_d = mem_req & ~mem_addr_ok;
        lock_owner_d = lock_valid_d ? grant_owner : lock_owner_q;
        starve_d     = starve_q;
        if (!inst_req || inst_addr_ok) begin
            starve_d = '0;
        end else if (mem_req && (grant_owner == OWNER_DATA) &&
                     (starve_q < STARVE_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STARVE_W'(1);
        end
        err_d = err_q | (mem_data_ok & fifo_empty);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_valid_q <= 1'b0;
            lock_owner_q <= OWNER_INST;
            starve_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            starve_q     <= starve_d;
            err_q        <= err_d;
        end
    end

    mem_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (grant_owner),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule : cpu_mem_arbiter
`default_nettype wire
